// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB slice first,
// with a registered carry chained between cycles. One operation at a time.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OW = $clog2(WIDTH);

  generate
    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [OW-1:0]    off;
  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT:0]   sl_sum;
  logic             last;

  always_comb begin
    off    = OW'(cnt) * OW'(DIGIT);
    a_sl   = a_r[off +: DIGIT];
    b_sl   = b_r[off +: DIGIT];
    sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
    last   = (cnt == CW'(N - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~borrow_in, so b and the carry seed are inverted at acceptance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b ^ {WIDTH{sub}};
          carry <= cin ^ sub;
          cnt   <= '0;
        end
        RUN: begin
          sum[off +: DIGIT] <= sl_sum[DIGIT-1:0];
          carry             <= sl_sum[DIGIT];
          cnt               <= cnt + CW'(1);
          if (last) begin
            cout <= sl_sum[DIGIT];
            // carry-in XOR carry-out of the MSB, expressed through operand/result signs
            ovf  <= (a_sl[DIGIT-1] == b_sl[DIGIT-1]) && (sl_sum[DIGIT-1] != a_sl[DIGIT-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit DIGIT=1 instance on directed vectors
// and three 4-bit instances (DIGIT 1, 2, 4) swept over every operand combination.
module tb_serial_adder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic [2:0] busy4, done4, cout4, ovf4;
  logic [3:0] sum4 [3];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .CLK(CLK), .RST(RST), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .CLK(CLK), .RST(RST), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0]));

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .CLK(CLK), .RST(RST), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1]));

  serial_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .CLK(CLK), .RST(RST), .start(start4), .sub(sub4), .cin(cin4), .a(a4), .b(b4),
    .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2]));

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       c;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  // Hand-computed: {cout,sum} = a+b+cin or a+~b+1-cin; ovf = signed overflow.
  vec_t vt [8] = '{
    '{a: 8'h7F, b: 8'h01, s: 1'b0, c: 1'b0, es: 8'h80, ec: 1'b0, eo: 1'b1},
    '{a: 8'hFF, b: 8'h01, s: 1'b0, c: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b0},
    '{a: 8'h0F, b: 8'h01, s: 1'b0, c: 1'b1, es: 8'h11, ec: 1'b0, eo: 1'b0},
    '{a: 8'h05, b: 8'h07, s: 1'b1, c: 1'b0, es: 8'hFE, ec: 1'b0, eo: 1'b0},
    '{a: 8'h80, b: 8'h01, s: 1'b1, c: 1'b0, es: 8'h7F, ec: 1'b1, eo: 1'b1},
    '{a: 8'h10, b: 8'h01, s: 1'b1, c: 1'b1, es: 8'h0E, ec: 1'b1, eo: 1'b0},
    '{a: 8'h80, b: 8'h80, s: 1'b0, c: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b1},
    '{a: 8'h00, b: 8'h00, s: 1'b1, c: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b0}
  };

  exp_t        q [4][$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic string unit_name(input int id);
    case (id)
      0:       return "w8d1";
      1:       return "w4d1";
      2:       return "w4d2";
      default: return "w4d4";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic scan(input int id, input logic d, input logic [7:0] s, input logic co,
                      input logic ov);
    exp_t e;
    if (d) begin
      if (q[id].size() == 0) begin
        check({unit_name(id), "_spurious_done"}, 32'(d), 32'd0);
      end else begin
        e = q[id].pop_front();
        check($sformatf("%s_result_due%0d", unit_name(id), e.due), {22'd0, co, ov, s},
              {22'd0, e.cout, e.ovf, e.sum});
        check({unit_name(id), "_done_latency"}, cyc, e.due);
      end
    end else if (q[id].size() != 0 && cyc > q[id][0].due + 2) begin
      e = q[id].pop_front();
      check({unit_name(id), "_done_timeout"}, 32'(d), 32'd1);
    end
  endtask

  function automatic logic [5:0] model4(input logic s, input logic c, input logic [3:0] x,
                                        input logic [3:0] y);
    int   xi, yi, ci, t, sx, sy, v;
    logic [5:0] r;
    xi = int'(x);
    yi = int'(y);
    ci = c ? 1 : 0;
    t  = s ? xi + (15 - yi) + (1 - ci) : xi + yi + ci;
    sx = (xi > 7) ? xi - 16 : xi;
    sy = (yi > 7) ? yi - 16 : yi;
    v  = s ? sx - sy - ci : sx + sy + ci;
    r[3:0] = t[3:0];
    r[4]   = (v < -8) || (v > 7);
    r[5]   = t[4];
    return r;
  endfunction

  // Called just after a negedge; start is sampled at the following posedge.
  task automatic issue8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                        input logic xc, input bit push, input logic [7:0] es,
                        input logic ec, input logic eo);
    a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
    if (push) q[0].push_back('{sum: es, cout: ec, ovf: eo, due: cyc + 9});
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle8(output int nb);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy && !done) break;
      if (busy) nb++;
      @(negedge CLK);
    end
  endtask

  int nb;
  logic [5:0] m;

  initial begin
    RST = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b0; a = 8'h7F; b = 8'h01;
    start4 = 1'b1; sub4 = 1'b0; cin4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    fork
      forever begin
        @(negedge CLK);
        scan(0, done, sum, cout, ovf);
        for (int i = 0; i < 3; i++) scan(i + 1, done4[i], {4'h0, sum4[i]}, cout4[i], ovf4[i]);
      end
    join_none

    // Reset wins over a simultaneous start.
    repeat (2) @(negedge CLK);
    check("reset_w8", {27'd0, busy, done, cout, ovf, sum}, 32'd0);
    check("reset_w4", {26'd0, busy4, done4}, 32'd0);
    RST = 1'b0; start = 1'b0; start4 = 1'b0;
    @(negedge CLK);
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    foreach (vt[i]) begin
      issue8(vt[i].a, vt[i].b, vt[i].s, vt[i].c, 1'b1, vt[i].es, vt[i].ec, vt[i].eo);
      wait_idle8(nb);
      check($sformatf("busy_cycles_vec%0d", i), nb, 32'd8);
      @(negedge CLK);
    end

    // Abort in the 4th busy cycle: nothing queued, so any later done is spurious.
    issue8(8'hAA, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    check("abort_busy4", 32'(busy), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_cleared", {27'd0, busy, done, cout, ovf, sum}, 32'd0);
    repeat (12) @(negedge CLK);
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    wait_idle8(nb);
    check("restart_busy_cycles", nb, 32'd8);
    @(negedge CLK);

    // Mid-run start pulse and operand changes must be ignored.
    issue8(8'h3C, 8'h21, 1'b0, 1'b0, 1'b1, 8'h5D, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle8(nb);
    check("ignored_busy_cycles", nb, 32'd5);
    repeat (3) @(negedge CLK);
    check("result_hold", {22'd0, cout, ovf, sum}, 32'h05D);
    issue8(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    wait_idle8(nb);
    check("next_accepted_busy", nb, 32'd8);
    @(negedge CLK);

    // Exhaustive 4-bit sweep; DIGIT=1 is back in IDLE six cycles after issue.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 512; x++) begin
        sub4 = s[0]; a4 = x[3:0]; b4 = x[7:4]; cin4 = x[8];
        m = model4(sub4, cin4, a4, b4);
        q[1].push_back('{sum: {4'h0, m[3:0]}, cout: m[5], ovf: m[4], due: cyc + 5});
        q[2].push_back('{sum: {4'h0, m[3:0]}, cout: m[5], ovf: m[4], due: cyc + 3});
        q[3].push_back('{sum: {4'h0, m[3:0]}, cout: m[5], ovf: m[4], due: cyc + 2});
        start4 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0;
        repeat (5) @(negedge CLK);
      end
    end

    repeat (10) @(negedge CLK);
    check("queues_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits processed per cycle; SHALL divide WIDTH exactly, checked at elaboration.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request one operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 cin  input  1  carry-in (add) / borrow-in (sub); sampled with start.
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-010 busy  output  1  high while digits are being processed.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry-out (add) / NOT borrow-out (sub).
REQ-014 ovf  output  1  signed overflow.

Function
REQ-015 FSM states: IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-016 IDLE: start=1 at an edge -> latch a, b XOR {WIDTH{sub}}, carry0 = cin XOR sub, clear digit counter, go to RUN.
REQ-017 IDLE: start=0 -> remain in IDLE.
REQ-018 RUN: each cycle adds one DIGIT-wide slice, LSB slice first, with carry chained cycle to cycle; result slice stored in the same position of sum.
REQ-019 RUN lasts exactly N cycles, then DONE; DONE lasts exactly one cycle, then IDLE.
REQ-020 Timing for start sampled at edge k: busy=1 in cycles k+1..k+N, done=1 in cycle k+N+1 only, earliest next accepted start at edge k+N+1.
REQ-021 busy=1 only in RUN; done=1 only in DONE.
REQ-022 start while in RUN or DONE is ignored, with no queueing.
REQ-023 a, b, sub, cin changes after acceptance do not affect the running operation.
REQ-024 Result: {cout, sum} = a + b + cin (add) or a + ~b + 1 - cin (sub), modulo 2^(WIDTH+1).
REQ-025 ovf = carry into MSB XOR carry out of MSB, computed in the final RUN cycle.
REQ-026 sum, cout and ovf are valid from the done cycle and hold until the next accepted start.
REQ-027 During RUN, sum may show partial results; only the done cycle qualifies sum.
REQ-028 DIGIT = WIDTH (N = 1) is legal: one RUN cycle.

Reset
REQ-029 RST=1 at an edge -> IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, regardless of state or start.
REQ-030 RST during RUN aborts the operation: no done pulse, and no partial result is held.
REQ-031 RST has priority over start in the same cycle.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=0x7F, b=0x01, sub=0, cin=0 -> busy 8 cycles, then done, sum=0x80, cout=0, ovf=1.
REQ-033 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, sub=0, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x0F, b=0x01, cin=1 -> sum=0x11.
REQ-034 WIDTH=8, DIGIT=1: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-035 Abort and restart: RST asserted in the 4th busy cycle -> next cycle busy=0, done=0, sum=0; a later start on a=0x12, b=0x34 -> sum=0x46 after a full 8 cycles.
REQ-036 Ignored inputs: start pulsed and a/b changed mid-RUN -> no extra operation and original result intact; next start accepted only after done.
REQ-037 WIDTH=4, DIGIT in {1, 2, 4}: all 2^9 (a, b, cin) combinations for each sub value match the golden model; done latency N+1 cycles after start.
